regfile_dump: RTL and testbench

Sequential debug reader for the MIPS register file: on a start pulse it walks an inclusive, wrap-around range of register indices through one register-file read port. It captures each value and streams (index, data) beats to a debug consumer over a valid/ready handshake. It sits beside the datapath on the register file's spare read port, enabling post-run inspection of architectural state without halting writeback logic.

---
 rtl/regfile_dump_if.sv | 29 ++
 rtl/regfile_dump.sv | 156 +++++++++++++++
 tb/tb_regfile_dump.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Bundle of control, register-file read port and debug stream signals for regfile_dump.
// The master modport is the dump engine; the slave modport is the surrounding environment.
interface regfile_dump_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic              start;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic [ADDR_W-1:0] rd_reg;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, first_reg, last_reg, rd_data, out_ready,
        output rd_reg, out_valid, out_idx, out_data, out_last, busy, done
    );

    modport slave (
        output start, first_reg, last_reg, rd_data, out_ready,
        input  rd_reg, out_valid, out_idx, out_data, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump.sv
// Debug reader: walks an inclusive wrap-around register range through a spare read port and streams (index, data) beats.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat (idx 0, out_last=1) after the last register beat.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_dump_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_rd_reg;
    logic [ADDR_W-1:0] w_rd_reg_nxt;
    logic [ADDR_W-1:0] r_last_reg;
    logic [ADDR_W-1:0] w_last_reg_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic [ADDR_W-1:0] r_out_idx;
    logic [ADDR_W-1:0] w_out_idx_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              r_out_last;
    logic              w_out_last_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_accept;
    logic              w_range_end;
    logic [ADDR_W-1:0] w_rd_reg_inc;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
    logic [DATA_W-1:0] w_csum_nxt;
    logic              r_last_beat;
    logic              w_last_beat_nxt;
`endif

    assign w_accept     = r_out_valid && bus.out_ready;
    assign w_range_end  = (r_rd_reg == r_last_reg);
    assign w_rd_reg_inc = ADDR_W'((int'(r_rd_reg) + 1) % NUM_REGS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rd_reg_nxt    = r_rd_reg;
        w_last_reg_nxt  = r_last_reg;
        w_out_valid_nxt = r_out_valid;
        w_out_idx_nxt   = r_out_idx;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        w_done_nxt      = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        w_csum_nxt      = r_csum;
        w_last_beat_nxt = r_last_beat;
`endif
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_rd_reg_nxt   = bus.first_reg;
                    w_last_reg_nxt = bus.last_reg;
`ifdef REGDUMP_CHECKSUM_EN
                    w_csum_nxt     = '0;
`endif
                    w_state_nxt    = READ;
                end
            end
            READ: begin
                w_out_data_nxt  = bus.rd_data;
                w_out_idx_nxt   = r_rd_reg;
                w_out_valid_nxt = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                w_out_last_nxt  = 1'b0;
                w_last_beat_nxt = w_range_end;
                w_csum_nxt      = r_csum ^ bus.rd_data;
`else
                w_out_last_nxt  = w_range_end;
`endif
                w_state_nxt     = SEND;
            end
            SEND: begin
                if (w_accept) begin
                    if (r_out_last) begin
                        w_out_valid_nxt = 1'b0;
                        w_done_nxt      = 1'b1;
                        w_state_nxt     = IDLE;
`ifdef REGDUMP_CHECKSUM_EN
                    // Checksum beat follows the last register beat without another READ.
                    end else if (r_last_beat) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_idx_nxt   = '0;
                        w_out_data_nxt  = r_csum;
                        w_out_last_nxt  = 1'b1;
                        w_last_beat_nxt = 1'b0;
`endif
                    end else begin
                        w_out_valid_nxt = 1'b0;
                        w_rd_reg_nxt    = w_rd_reg_inc;
                        w_state_nxt     = READ;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_reg    <= '0;
            r_last_reg  <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            r_csum      <= '0;
            r_last_beat <= 1'b0;
`endif
        end else begin
            r_rd_reg    <= w_rd_reg_nxt;
            r_last_reg  <= w_last_reg_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
            r_done      <= w_done_nxt;
`ifdef REGDUMP_CHECKSUM_EN
            r_csum      <= w_csum_nxt;
            r_last_beat <= w_last_beat_nxt;
`endif
        end
    end

    assign bus.rd_reg    = r_rd_reg;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump: a register-file array drives the read port and a range-walk model predicts each dump.
// REGDUMP_CHECKSUM_EN, when defined, also enables the checksum expectations and test.
module tb_regfile_dump;
    logic        clk;
    logic        rst_n;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [31:0] regs [32];
    logic [3:0]  readyPattern;

    int total = 0;
    int bad   = 0;

    logic [37:0] gotBeats [$];
    logic [37:0] expBeats [$];
    int          doneAt;
    int          expDone;
    int          holdErr;
    logic        busyAtStart;
    logic        busyAtDone;
    logic [4:0]  rdAtStart;

    regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rd_data = regs[bus.rd_reg];

    always @(posedge clk) begin
        if (wrEn) regs[wrAddr] <= wrData;
    end

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wrEn = 1'b1; wrAddr = a; wrData = d;
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    // Expected beat stream from the range rule: n = ((last-first) mod 32)+1 indices walking upward.
    function automatic void build_expect(input logic [4:0] f, input logic [4:0] l);
        int n;
        logic [4:0] idx;
`ifdef REGDUMP_CHECKSUM_EN
        logic [31:0] x;
        x = 32'd0;
`endif
        expBeats.delete();
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        for (int k = 0; k < n; k++) begin
            idx = 5'((int'(f) + k) % 32);
`ifdef REGDUMP_CHECKSUM_EN
            x = x ^ regs[idx];
            expBeats.push_back({idx, regs[idx], 1'b0});
`else
            expBeats.push_back({idx, regs[idx], (k == n - 1)});
`endif
        end
`ifdef REGDUMP_CHECKSUM_EN
        expBeats.push_back({5'd0, x, 1'b1});
        expDone = 2 * n + 1;
`else
        expDone = 2 * n;
`endif
    endfunction

    // Runs one dump from a negedge; returns at the negedge where done is seen (or after the cycle budget).
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input int startAt, input int writeAt,
                            input logic [4:0] wAddr, input logic [31:0] wData);
        logic        heldValid;
        logic [37:0] heldBeat;
        logic [37:0] curBeat;
        logic        rdy;
        int          cyc;
        gotBeats.delete();
        doneAt = -1; holdErr = 0; heldValid = 1'b0; busyAtDone = 1'b1; heldBeat = '0;
        bus.first_reg = f; bus.last_reg = l; bus.start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.first_reg = ~f; bus.last_reg = ~l;
        busyAtStart = bus.busy; rdAtStart = bus.rd_reg;
        cyc = 0;
        while (cyc < 600) begin
            if (bus.done) begin
                doneAt = cyc; busyAtDone = bus.busy;
                break;
            end
            curBeat = {bus.out_idx, bus.out_data, bus.out_last};
            if (heldValid && (!bus.out_valid || curBeat !== heldBeat)) holdErr++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = readyPattern[cyc % 4];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            bus.start = (cyc == startAt);
            wrEn = (cyc == writeAt); wrAddr = wAddr; wrData = wData;
            if (bus.out_valid && rdy) gotBeats.push_back(curBeat);
            heldValid = bus.out_valid && !rdy;
            heldBeat = curBeat;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0; wrEn = 1'b0; bus.out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.start = 1'b0; bus.first_reg = '0; bus.last_reg = '0; bus.out_ready = 1'b0;
        wrEn = 1'b0; wrAddr = '0; wrData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.rd_reg, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, bus.busy, bus.done} !== 46'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got rd=%0d v=%b idx=%0d data=%h last=%b busy=%b done=%b want all zero",
                     bus.rd_reg, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_idle_busy got=%b want=0", bus.busy);
        end
    endtask

    task automatic test_full_range;
        for (int k = 0; k < 32; k++) write_reg(5'(k), 32'h1000 + k);
        build_expect(5'd0, 5'd31);
        run_dump(5'd0, 5'd31, 0, -1, -1, 5'd0, 32'd0);
        total++;
        if (gotBeats.size() !== expBeats.size()) begin
            bad++; $display("[TB] FAIL full_count got=%0d want=%0d", gotBeats.size(), expBeats.size());
        end
        for (int i = 0; i < gotBeats.size() && i < expBeats.size(); i++) begin
            total++;
            if (gotBeats[i] !== expBeats[i]) begin
                bad++; $display("[TB] FAIL full_beat%0d got=%h want=%h", i, gotBeats[i], expBeats[i]);
            end
        end
        total++;
        if (busyAtStart !== 1'b1 || rdAtStart !== 5'd0) begin
            bad++; $display("[TB] FAIL full_start got busy=%b rd=%0d want busy=1 rd=0", busyAtStart, rdAtStart);
        end
        total++;
        if (doneAt !== expDone) begin
            bad++; $display("[TB] FAIL full_done_time got=%0d want=%0d", doneAt, expDone);
        end
        total++;
        if (busyAtDone !== 1'b0) begin
            bad++; $display("[TB] FAIL full_busy_at_done got=%b want=0", busyAtDone);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("[TB] FAIL full_done_pulse got done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_backpressure;
        readyPattern = 4'b1001;
        @(negedge clk);
        build_expect(5'd5, 5'd7);
        run_dump(5'd5, 5'd7, 1, -1, -1, 5'd0, 32'd0);
        total++;
        if (gotBeats.size() !== expBeats.size()) begin
            bad++; $display("[TB] FAIL bp_count got=%0d want=%0d", gotBeats.size(), expBeats.size());
        end
        for (int i = 0; i < gotBeats.size() && i < expBeats.size(); i++) begin
            total++;
            if (gotBeats[i] !== expBeats[i]) begin
                bad++; $display("[TB] FAIL bp_beat%0d got=%h want=%h", i, gotBeats[i], expBeats[i]);
            end
        end
        total++;
        if (holdErr !== 0) begin
            bad++; $display("[TB] FAIL bp_hold_stable got=%0d changes want=0", holdErr);
        end
        total++;
        if (doneAt < expDone) begin
            bad++; $display("[TB] FAIL bp_done got=%0d want>=%0d", doneAt, expDone);
        end
    endtask

    task automatic test_wrap_single;
        @(negedge clk);
        build_expect(5'd30, 5'd1);
        run_dump(5'd30, 5'd1, 0, -1, -1, 5'd0, 32'd0);
        total++;
        if (gotBeats.size() !== expBeats.size()) begin
            bad++; $display("[TB] FAIL wrap_count got=%0d want=%0d", gotBeats.size(), expBeats.size());
        end
        for (int i = 0; i < gotBeats.size() && i < expBeats.size(); i++) begin
            total++;
            if (gotBeats[i] !== expBeats[i]) begin
                bad++; $display("[TB] FAIL wrap_beat%0d got=%h want=%h", i, gotBeats[i], expBeats[i]);
            end
        end
        @(negedge clk);
        build_expect(5'd12, 5'd12);
        run_dump(5'd12, 5'd12, 0, -1, -1, 5'd0, 32'd0);
        total++;
        if (gotBeats.size() !== expBeats.size() || gotBeats[0] !== expBeats[0]) begin
            bad++; $display("[TB] FAIL single_beat got n=%0d first=%h want n=%0d first=%h",
                            gotBeats.size(), gotBeats.size() > 0 ? gotBeats[0] : 38'd0, expBeats.size(), expBeats[0]);
        end
        total++;
        if (doneAt !== expDone) begin
            bad++; $display("[TB] FAIL single_done_time got=%0d want=%0d", doneAt, expDone);
        end
    endtask

    task automatic test_start_busy;
        @(negedge clk);
        build_expect(5'd10, 5'd14);
        run_dump(5'd10, 5'd14, 0, 3, -1, 5'd0, 32'd0);
        total++;
        if (gotBeats.size() !== expBeats.size()) begin
            bad++; $display("[TB] FAIL busy_start_count got=%0d want=%0d", gotBeats.size(), expBeats.size());
        end
        for (int i = 0; i < gotBeats.size() && i < expBeats.size(); i++) begin
            total++;
            if (gotBeats[i] !== expBeats[i]) begin
                bad++; $display("[TB] FAIL busy_start_beat%0d got=%h want=%h", i, gotBeats[i], expBeats[i]);
            end
        end
        total++;
        if (doneAt !== expDone) begin
            bad++; $display("[TB] FAIL busy_start_done got=%0d want=%0d", doneAt, expDone);
        end
    endtask

    // Second dump starts in the very cycle the first one reports done.
    task automatic test_back_to_back;
        @(negedge clk);
        run_dump(5'd20, 5'd21, 0, -1, -1, 5'd0, 32'd0);
        build_expect(5'd2, 5'd4);
        run_dump(5'd2, 5'd4, 0, -1, -1, 5'd0, 32'd0);
        total++;
        if (gotBeats.size() !== expBeats.size()) begin
            bad++; $display("[TB] FAIL b2b_count got=%0d want=%0d", gotBeats.size(), expBeats.size());
        end
        for (int i = 0; i < gotBeats.size() && i < expBeats.size(); i++) begin
            total++;
            if (gotBeats[i] !== expBeats[i]) begin
                bad++; $display("[TB] FAIL b2b_beat%0d got=%h want=%h", i, gotBeats[i], expBeats[i]);
            end
        end
        total++;
        if (doneAt !== expDone) begin
            bad++; $display("[TB] FAIL b2b_done got=%0d want=%0d", doneAt, expDone);
        end
    endtask

    task automatic test_reset_mid;
        logic found;
        logic sawDone;
        @(negedge clk);
        bus.first_reg = 5'd0; bus.last_reg = 5'd31; bus.start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.out_valid && bus.out_idx == 5'd2) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (found !== 1'b1) begin
            bad++; $display("[TB] FAIL rstmid_reach_beat3 got=%b want=1", found);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.rd_reg, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, bus.busy, bus.done} !== 46'd0) begin
            bad++;
            $display("[TB] FAIL rstmid_outputs got rd=%0d v=%b idx=%0d data=%h last=%b busy=%b done=%b want all zero",
                     bus.rd_reg, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) sawDone = 1'b1;
        end
        total++;
        if (sawDone !== 1'b0) begin
            bad++; $display("[TB] FAIL rstmid_no_done got activity=%b want=0", sawDone);
        end
        build_expect(5'd0, 5'd31);
        run_dump(5'd0, 5'd31, 0, -1, -1, 5'd0, 32'd0);
        total++;
        if (gotBeats.size() !== expBeats.size()) begin
            bad++; $display("[TB] FAIL rstmid_redo_count got=%0d want=%0d", gotBeats.size(), expBeats.size());
        end
        for (int i = 0; i < gotBeats.size() && i < expBeats.size(); i++) begin
            total++;
            if (gotBeats[i] !== expBeats[i]) begin
                bad++; $display("[TB] FAIL rstmid_redo_beat%0d got=%h want=%h", i, gotBeats[i], expBeats[i]);
            end
        end
    endtask

    // Write to reg 4 lands on the edge that closes reg 4's READ (third edge after start for range 3..5).
    task automatic test_concurrent_write;
        @(negedge clk);
        build_expect(5'd3, 5'd5);
        run_dump(5'd3, 5'd5, 0, -1, 2, 5'd4, 32'hDEADBEEF);
        total++;
        if (gotBeats.size() !== expBeats.size()) begin
            bad++; $display("[TB] FAIL cw_old_count got=%0d want=%0d", gotBeats.size(), expBeats.size());
        end
        for (int i = 0; i < gotBeats.size() && i < expBeats.size(); i++) begin
            total++;
            if (gotBeats[i] !== expBeats[i]) begin
                bad++; $display("[TB] FAIL cw_old_beat%0d got=%h want=%h", i, gotBeats[i], expBeats[i]);
            end
        end
        @(negedge clk);
        build_expect(5'd3, 5'd5);
        run_dump(5'd3, 5'd5, 0, -1, -1, 5'd0, 32'd0);
        total++;
        if (gotBeats.size() < 2 || gotBeats[1][32:1] !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL cw_new_value got=%h want data DEADBEEF",
                            gotBeats.size() > 1 ? gotBeats[1] : 38'd0);
        end
    endtask

    task automatic test_random;
        logic [4:0] f;
        logic [4:0] l;
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 32; k++) write_reg(5'(k), $urandom);
            f = 5'($urandom_range(0, 31));
            l = 5'($urandom_range(0, 31));
            build_expect(f, l);
            run_dump(f, l, 2, -1, -1, 5'd0, 32'd0);
            total++;
            if (gotBeats.size() !== expBeats.size()) begin
                bad++; $display("[TB] FAIL rand%0d_count range=%0d..%0d got=%0d want=%0d", t, f, l, gotBeats.size(), expBeats.size());
            end
            for (int i = 0; i < gotBeats.size() && i < expBeats.size(); i++) begin
                total++;
                if (gotBeats[i] !== expBeats[i]) begin
                    bad++; $display("[TB] FAIL rand%0d_beat%0d got=%h want=%h", t, i, gotBeats[i], expBeats[i]);
                end
            end
            total++;
            if (holdErr !== 0 || doneAt < expDone) begin
                bad++; $display("[TB] FAIL rand%0d_hold_done got hold=%0d done=%0d want hold=0 done>=%0d", t, holdErr, doneAt, expDone);
            end
        end
    endtask

`ifdef REGDUMP_CHECKSUM_EN
    task automatic test_checksum;
        write_reg(5'd1, 32'h1);
        write_reg(5'd2, 32'h2);
        write_reg(5'd3, 32'h4);
        build_expect(5'd1, 5'd3);
        run_dump(5'd1, 5'd3, 0, -1, -1, 5'd0, 32'd0);
        total++;
        if (gotBeats.size() !== 4) begin
            bad++; $display("[TB] FAIL csum_count got=%0d want=4", gotBeats.size());
        end
        for (int i = 0; i < gotBeats.size() && i < expBeats.size(); i++) begin
            total++;
            if (gotBeats[i] !== expBeats[i]) begin
                bad++; $display("[TB] FAIL csum_beat%0d got=%h want=%h", i, gotBeats[i], expBeats[i]);
            end
        end
        total++;
        if (doneAt !== 7) begin
            bad++; $display("[TB] FAIL csum_done got=%0d want=7", doneAt);
        end
    endtask
`endif

    initial begin
        readyPattern = 4'b1001;
        test_reset();
        test_full_range();
        test_backpressure();
        test_wrap_single();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_concurrent_write();
        test_random();
`ifdef REGDUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
